// File: rtl/scroll_message_controller_pkg.sv
// -----------------------------------------------------------------------------
// scroll_message_controller_pkg
// Shared definitions for the scrolling message controller:
//   - segment bit order and the blank pattern (segments are active-low)
//   - character codes beyond the hex digits
//   - controller state encoding
// -----------------------------------------------------------------------------
package scroll_message_controller_pkg;

    // Segment vector order is {g,f,e,d,c,b,a}; bit 0 is segment a.
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;

    // Active-low: all ones lights nothing.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Codes 0..15 are hex digits; the rest are below. 21..31 decode as blank.
    localparam logic [4:0] CH_BLANK = 5'd16;
    localparam logic [4:0] CH_DASH  = 5'd17;
    localparam logic [4:0] CH_H     = 5'd18;
    localparam logic [4:0] CH_L     = 5'd19;
    localparam logic [4:0] CH_P     = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_message_controller_if.sv
// -----------------------------------------------------------------------------
// scroll_message_controller_if
// Character load bus into the message buffer.
// Handshake: a character transfers on a rising clock edge where load_valid and
// load_ready are both high. load_char/load_last are only meaningful while
// load_valid is high; load_ready may drop without waiting for load_valid.
//   load_valid  master->slave  write request
//   load_ready  slave->master  buffer accepts a char this cycle
//   load_char   master->slave  5-bit character code
//   load_last   master->slave  marks load_char as the final char of the message
// -----------------------------------------------------------------------------
interface scroll_message_controller_if;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_char;
    logic       load_last;

    modport master (
        output load_valid,
        output load_char,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_char,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/scroll_message_controller_decoder.sv
// -----------------------------------------------------------------------------
// seg7_char_decoder
// Combinational 5-bit character code to 7-bit active-low segment pattern.
//   code  in  5  character code (0-15 hex, 16 blank, 17 '-', 18 H, 19 L, 20 P)
//   seg   out 7  {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module seg7_char_decoder
    import scroll_message_controller_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b0000011;
            5'd12:   seg = 7'b1000110;
            5'd13:   seg = 7'b0100001;
            5'd14:   seg = 7'b0000110;
            5'd15:   seg = 7'b0001110;
            CH_DASH: seg = 7'b0111111;
            CH_H:    seg = 7'b0001001;
            CH_L:    seg = 7'b1000111;
            CH_P:    seg = 7'b0001100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scroll_message_controller.sv
// -----------------------------------------------------------------------------
// scroll_message_controller
// Stores a short character message and feeds it, one char per paced strobe,
// into the six-digit 7-segment shift register so the text scrolls. At the end
// of the message it either wraps (loop_mode) or pushes NUM_DIGITS blanks.
//   clock        in   system clock, rising edge
//   En           in   asynchronous active-low reset
//   load_bus     slave modport: load_valid/load_ready/load_char/load_last
//   start        in   1-cycle pulse, begin scrolling (IDLE only)
//   stop         in   1-cycle pulse, abort scrolling and flush the display
//   loop_mode    in   1 = wrap to first char, sampled at each end of message
//   seg_out      out  active-low {g,f,e,d,c,b,a} to shift register Din
//   shift_pulse  out  1-cycle strobe, shift register captures seg_out
//   busy         out  high in SCROLL and FLUSH
//   msg_len      out  number of chars stored
//   dbg_state    out  current controller state
// -----------------------------------------------------------------------------
module scroll_message_controller
    import scroll_message_controller_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int MSG_DEPTH  = 16,
    parameter int NUM_DIGITS = 6
) (
    input  logic                         clock,
    input  logic                         En,
    scroll_message_controller_if.slave   load_bus,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_mode,
    output logic [6:0]                   seg_out,
    output logic                         shift_pulse,
    output logic                         busy,
    output logic [4:0]                   msg_len,
    output state_t                       dbg_state
);

    localparam int PW    = $clog2(TICK_DIV);
    localparam int IDX_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int FW    = $clog2(NUM_DIGITS + 1);

    state_t           state;
    logic [PW-1:0]    prescaler;
    logic [IDX_W-1:0] index;
    logic [FW-1:0]    flush_cnt;
    logic             msg_closed;
    logic [4:0]       msg_buf [MSG_DEPTH];

    logic             wr_fire;
    logic [4:0]       wr_len;
    logic [IDX_W-1:0] wr_addr;
    logic             tick;
    logic             at_last;
    logic [6:0]       dec_seg;

    assign dbg_state = state;

    // Loads only in IDLE so the message cannot change under a running scroll.
    assign load_bus.load_ready = (state == ST_IDLE) && (msg_len < 5'(MSG_DEPTH));
    assign wr_fire = load_bus.load_valid && load_bus.load_ready;

    // A closed message is replaced from entry 0 by the next write.
    assign wr_len  = msg_closed ? 5'd1 : msg_len + 5'd1;
    assign wr_addr = msg_closed ? '0 : msg_len[IDX_W-1:0];

    assign tick    = (prescaler == PW'(TICK_DIV - 1));
    assign at_last = (5'(index) == msg_len - 5'd1);

    seg7_char_decoder u_decoder (
        .code (msg_buf[index]),
        .seg  (dec_seg)
    );

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            msg_buf[wr_addr] <= load_bus.load_char;
        end
    end

    always_ff @(posedge clock or negedge En) begin
        if (!En) begin
            state       <= ST_IDLE;
            seg_out     <= SEG_BLANK;
            shift_pulse <= 1'b0;
            busy        <= 1'b0;
            msg_len     <= 5'd0;
            prescaler   <= '0;
            index       <= '0;
            flush_cnt   <= '0;
            msg_closed  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    shift_pulse <= 1'b0;
                    if (wr_fire) begin
                        msg_len    <= wr_len;
                        msg_closed <= load_bus.load_last || (wr_len == 5'(MSG_DEPTH));
                    end else if (start && !stop && (msg_len != 5'd0)) begin
                        state     <= ST_SCROLL;
                        busy      <= 1'b1;
                        index     <= '0;
                        prescaler <= '0;
                    end
                end

                ST_SCROLL: begin
                    if (stop) begin
                        shift_pulse <= 1'b0;
                        prescaler   <= '0;
                        flush_cnt   <= '0;
                        state       <= ST_FLUSH;
                    end else if (tick) begin
                        prescaler   <= '0;
                        shift_pulse <= 1'b1;
                        seg_out     <= dec_seg;
                        if (!at_last) begin
                            index <= index + 1'b1;
                        end else if (loop_mode) begin
                            index <= '0;
                        end else begin
                            flush_cnt <= '0;
                            state     <= ST_FLUSH;
                        end
                    end else begin
                        prescaler   <= prescaler + 1'b1;
                        shift_pulse <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    // flush_cnt reaches NUM_DIGITS on the last blank strobe;
                    // the following cycle returns to IDLE.
                    if (flush_cnt == FW'(NUM_DIGITS)) begin
                        shift_pulse <= 1'b0;
                        prescaler   <= '0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (tick) begin
                        prescaler   <= '0;
                        shift_pulse <= 1'b1;
                        seg_out     <= SEG_BLANK;
                        flush_cnt   <= flush_cnt + 1'b1;
                    end else begin
                        prescaler   <= prescaler + 1'b1;
                        shift_pulse <= 1'b0;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    shift_pulse <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_message_controller.sv
// -----------------------------------------------------------------------------
// tb_scroll_message_controller
// Directed bench for scroll_message_controller with TICK_DIV=4, MSG_DEPTH=16,
// NUM_DIGITS=6. Inputs change on the falling edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_scroll_message_controller;
    import scroll_message_controller_pkg::*;

    localparam int TICK_DIV   = 4;
    localparam int MSG_DEPTH  = 16;
    localparam int NUM_DIGITS = 6;

    // Hand-written active-low patterns {g,f,e,d,c,b,a} for 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_H    = 7'h09;
    localparam logic [6:0] SEG_L    = 7'h47;
    localparam logic [6:0] SEG_P    = 7'h0C;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic En;
    always #5 clock = ~clock;

    logic       start, stop, loop_mode;
    logic [6:0] seg_out;
    logic       shift_pulse, busy;
    logic [4:0] msg_len;
    state_t     dbg_state;

    scroll_message_controller_if lb ();

    scroll_message_controller #(
        .TICK_DIV   (TICK_DIV),
        .MSG_DEPTH  (MSG_DEPTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clock       (clock),
        .En          (En),
        .load_bus    (lb),
        .start       (start),
        .stop        (stop),
        .loop_mode   (loop_mode),
        .seg_out     (seg_out),
        .shift_pulse (shift_pulse),
        .busy        (busy),
        .msg_len     (msg_len),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        En = 1'b0;
        repeat (2) @(negedge clock);
        En = 1'b1;
        @(negedge clock);
    endtask

    task automatic drive_load(input logic [4:0] c, input logic last);
        lb.load_valid = 1'b1;
        lb.load_char  = c;
        lb.load_last  = last;
        @(negedge clock);
        lb.load_valid = 1'b0;
        lb.load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
    endtask

    // Waits for the next strobe (bounded) and checks its spacing and value.
    task automatic wait_strobe(input string tag, input logic [6:0] exp_seg, input int exp_gap);
        int  gap  = 0;
        bit  seen = 0;
        while (!seen && gap < 40) begin
            @(negedge clock);
            gap++;
            if (shift_pulse) seen = 1;
        end
        check_eq($sformatf("%s_gap", tag), gap, exp_gap);
        check_eq($sformatf("%s_seg", tag), {25'd0, seg_out}, {25'd0, exp_seg});
    endtask

    // Drains exp_q as a sequence of strobes, TICK_DIV apart.
    task automatic expect_chars(input string tag);
        int k = 0;
        while (exp_q.size() > 0) begin
            wait_strobe($sformatf("%s_c%0d", tag, k), exp_q.pop_front(), TICK_DIV);
            k++;
        end
    endtask

    task automatic expect_flush(input string tag, input int first_gap);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            wait_strobe($sformatf("%s_b%0d", tag, i), SEG_BLANK, (i == 0) ? first_gap : TICK_DIV);
        end
        @(negedge clock);
        check_eq($sformatf("%s_busy_end", tag), {31'd0, busy}, 32'd0);
        check_eq($sformatf("%s_state_end", tag), 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq($sformatf("%s_seg", tag),   {25'd0, seg_out}, 32'h7F);
        check_eq($sformatf("%s_pulse", tag), {31'd0, shift_pulse}, 32'd0);
        check_eq($sformatf("%s_busy", tag),  {31'd0, busy}, 32'd0);
        check_eq($sformatf("%s_len", tag),   {27'd0, msg_len}, 32'd0);
        check_eq($sformatf("%s_rdy", tag),   {31'd0, lb.load_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        En = 1'b0;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        lb.load_valid = 1'b0; lb.load_char = 5'd0; lb.load_last = 1'b0;

        // 1: reset values
        repeat (2) @(negedge clock);
        check_reset_values("t1");
        En = 1'b1;
        @(negedge clock);

        // 2: one-shot scroll of 1,2,3 then six blanks; writes ignored while busy
        drive_load(5'd1, 1'b0);
        drive_load(5'd2, 1'b0);
        drive_load(5'd3, 1'b1);
        check_eq("t2_len", {27'd0, msg_len}, 32'd3);
        loop_mode = 1'b0;
        pulse_start();
        wait_strobe("t2_c0", HEX_SEG[1], TICK_DIV);
        check_eq("t2_rdy_busy", {31'd0, lb.load_ready}, 32'd0);
        lb.load_valid = 1'b1;
        lb.load_char  = 5'd7;
        wait_strobe("t2_c1", HEX_SEG[2], TICK_DIV);
        lb.load_valid = 1'b0;
        wait_strobe("t2_c2", HEX_SEG[3], TICK_DIV);
        expect_flush("t2", TICK_DIV);
        check_eq("t2_len_frozen", {27'd0, msg_len}, 32'd3);

        // 3: loop mode wraps back to the first char, then stop flushes
        loop_mode = 1'b1;
        exp_q.push_back(HEX_SEG[1]);
        exp_q.push_back(HEX_SEG[2]);
        exp_q.push_back(HEX_SEG[3]);
        exp_q.push_back(HEX_SEG[1]);
        pulse_start();
        expect_chars("t3");
        check_eq("t3_busy_loop", {31'd0, busy}, 32'd1);
        pulse_stop();
        expect_flush("t3", TICK_DIV);

        // 4: stop after second strobe
        loop_mode = 1'b0;
        exp_q.push_back(HEX_SEG[1]);
        exp_q.push_back(HEX_SEG[2]);
        pulse_start();
        expect_chars("t4");
        pulse_stop();
        expect_flush("t4", TICK_DIV);

        // 5: fill the buffer without load_last, then scroll all sixteen digits
        do_reset();
        for (int i = 0; i < 16; i++) drive_load(5'(i), 1'b0);
        check_eq("t5_len_full", {27'd0, msg_len}, 32'd16);
        check_eq("t5_rdy_full", {31'd0, lb.load_ready}, 32'd0);
        drive_load(5'd9, 1'b0);
        check_eq("t5_len_17th", {27'd0, msg_len}, 32'd16);
        for (int i = 0; i < 16; i++) exp_q.push_back(HEX_SEG[i]);
        pulse_start();
        expect_chars("t5");
        expect_flush("t5", TICK_DIV);

        // start with an empty buffer is ignored
        do_reset();
        pulse_start();
        repeat (3) @(negedge clock);
        check_eq("t5_empty_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_empty_pulse", {31'd0, shift_pulse}, 32'd0);

        // a write after a closed message restarts it
        drive_load(5'd1, 1'b0);
        drive_load(5'd2, 1'b0);
        drive_load(5'd3, 1'b1);
        check_eq("t5_len_closed", {27'd0, msg_len}, 32'd3);
        drive_load(5'd5, 1'b0);
        check_eq("t5_len_restart", {27'd0, msg_len}, 32'd1);

        // write wins over start in the same cycle
        lb.load_valid = 1'b1;
        lb.load_char  = 5'd4;
        start = 1'b1;
        @(negedge clock);
        lb.load_valid = 1'b0;
        start = 1'b0;
        check_eq("t5_wr_vs_start_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_wr_vs_start_len", {27'd0, msg_len}, 32'd2);

        // stop beats start
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("t5_stop_vs_start", {31'd0, busy}, 32'd0);

        // letters and symbols: message 5,4,-,H,L,P,blank
        drive_load(CH_DASH, 1'b0);
        drive_load(CH_H, 1'b0);
        drive_load(CH_L, 1'b0);
        drive_load(CH_P, 1'b0);
        drive_load(CH_BLANK, 1'b1);
        check_eq("t5_len_sym", {27'd0, msg_len}, 32'd7);
        exp_q.push_back(HEX_SEG[5]);
        exp_q.push_back(HEX_SEG[4]);
        exp_q.push_back(SEG_DASH);
        exp_q.push_back(SEG_H);
        exp_q.push_back(SEG_L);
        exp_q.push_back(SEG_P);
        exp_q.push_back(SEG_BLANK);
        pulse_start();
        expect_chars("t5s");
        expect_flush("t5s", TICK_DIV);

        // 6: asynchronous reset in the middle of a scroll
        exp_q.push_back(HEX_SEG[5]);
        pulse_start();
        expect_chars("t6");
        @(negedge clock);
        #2 En = 1'b0;
        #1;
        check_eq("t6_seg",   {25'd0, seg_out}, 32'h7F);
        check_eq("t6_pulse", {31'd0, shift_pulse}, 32'd0);
        check_eq("t6_busy",  {31'd0, busy}, 32'd0);
        check_eq("t6_len",   {27'd0, msg_len}, 32'd0);
        @(negedge clock);
        En = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (shift_pulse) pulses++;
        end
        check_eq("t6_no_strobe", pulses, 32'd0);
        check_eq("t6_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
